// File: rtl/stage_prefetch.sv
// stage_prefetch: instruction prefetch stage with a DEPTH-entry queue.
//
// A fetch PC register issues requests to instruction memory. Each
// instruction that memory acknowledges is queued as {insn, pc} and is
// handed to decode in FIFO order. A redirect (pc_wen) flushes the queue
// and retargets fetch in the same cycle.
//
// Ports:
//   clk, reset_n          clock; synchronous active-low reset
//   fe_enable             fetch permit from the mem stage
//   pc_wen, pc_in         redirect strobe and target
//   fe_req, fe_addr       memory request and address
//   fe_ack, fe_data       same-cycle memory acknowledge and instruction
//   de_ready              decode accepts the head entry
//   de_valid, de_insn,    head entry valid / instruction / address
//   de_pc
//   occupancy             number of queued entries
//
// Optional feature macro: STAGE_PREFETCH_BYPASS_EN
//   When defined, an instruction acknowledged into an empty queue is shown
//   to decode in the same cycle, and is queued only if decode stalls.

module stage_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       fe_enable,
    input  logic                       pc_wen,
    input  logic [31:0]                pc_in,
    output logic                       fe_req,
    output logic [31:0]                fe_addr,
    input  logic                       fe_ack,
    input  logic [31:0]                fe_data,
    input  logic                       de_ready,
    output logic                       de_valid,
    output logic [31:0]                de_insn,
    output logic [31:0]                de_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] count;
    logic [31:0]      insn_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    logic fetch_ok;
    logic q_valid;
    logic push;
    logic pop;

    assign fe_addr   = pc_wen ? pc_in : fetch_pc;
    assign fe_req    = fe_enable & (count < DEPTH_C);
    // An acknowledge arriving while reset is asserted is dropped.
    assign fetch_ok  = fe_req & fe_ack & reset_n;
    // The head is hidden during a redirect (it is being flushed) and during
    // reset, so decode never sees a handshake on a discarded entry.
    assign q_valid   = (count != '0) & ~pc_wen & reset_n;
    assign pop       = q_valid & de_ready;
    assign occupancy = count;

`ifdef STAGE_PREFETCH_BYPASS_EN
    logic bypass;

    assign bypass   = (count == '0) & ~pc_wen & fetch_ok;
    assign de_valid = q_valid | bypass;
    assign de_insn  = bypass ? fe_data : insn_mem[rd_ptr];
    assign de_pc    = bypass ? fe_addr : pc_mem[rd_ptr];
    // A bypassed instruction consumed by decode this cycle is never queued.
    assign push     = fetch_ok & ~(bypass & de_ready);
`else
    assign de_valid = q_valid;
    assign de_insn  = insn_mem[rd_ptr];
    assign de_pc    = pc_mem[rd_ptr];
    assign push     = fetch_ok;
`endif

    // A redirect restarts the queue at slot 0, so the target lands there.
    assign wr_idx = pc_wen ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= RESET_PC;
        end else if (pc_wen) begin
            rd_ptr   <= '0;
            wr_ptr   <= push ? PTR_W'(1) : '0;
            count    <= push ? CNT_W'(1) : '0;
            fetch_pc <= fetch_ok ? (fe_addr + 32'd4) : pc_in;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (fetch_ok) begin
                fetch_pc <= fe_addr + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            insn_mem[wr_idx] <= fe_data;
            pc_mem[wr_idx]   <= fe_addr;
        end
    end

endmodule

// File: doc/stage_prefetch.md
STAGE_PREFETCH -- requirements
Module: stage_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning instruction-queue entries; power of two, >=2.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h80000000, meaning first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, reset, synchronous, active-low.
REQ-005 The block SHALL have port fe_enable, input, 1, fetch permit from the mem stage.
REQ-006 The block SHALL have port pc_wen, input, 1, redirect strobe.
REQ-007 The block SHALL have port pc_in, input, 32, redirect target.
REQ-008 The block SHALL have port fe_req, output, 1, memory request.
REQ-009 The block SHALL have port fe_addr, output, 32, request address.
REQ-010 The block SHALL have port fe_ack, input, 1, same-cycle memory acknowledge.
REQ-011 The block SHALL have port fe_data, input, 32, instruction returned with fe_ack.
REQ-012 The block SHALL have port de_ready, input, 1, decode accepts head entry.
REQ-013 The block SHALL have port de_valid, output, 1, head entry valid.
REQ-014 The block SHALL have port de_insn, output, 32, head instruction.
REQ-015 The block SHALL have port de_pc, output, 32, head instruction address.
REQ-016 The block SHALL have port occupancy, output, $clog2(DEPTH)+1, queued entry count.

Function
REQ-017 The block SHALL hold a fetch PC register and a DEPTH-entry FIFO of {insn, pc} with read/write pointers and a count.
REQ-018 fe_addr SHALL equal pc_in when pc_wen=1, else the fetch PC.
REQ-019 fe_req SHALL equal fe_enable & (count < DEPTH); a pop in the same cycle SHALL NOT make a full queue request.
REQ-020 On fe_req & fe_ack the block SHALL push {fe_data, fe_addr} and load fetch PC with fe_addr+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-021 fe_ack while fe_req=0 SHALL be ignored.
REQ-022 de_valid SHALL equal (count != 0) & ~pc_wen; de_insn/de_pc SHALL show the head entry, combinationally.
REQ-023 A pop SHALL occur on de_valid & de_ready; simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-024 On pc_wen=1 all queued entries SHALL be discarded in that cycle (no pop); if fe_ack also occurs, the target's instruction SHALL be the sole entry next cycle (count=1), else count=0 and fetch PC=pc_in.
REQ-025 fe_enable=0 SHALL stop new requests only; queued entries SHALL continue to drain.
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy SHALL equal count.

Reset
REQ-027 While reset_n=0 at a clock edge: count, pointers <= 0; fetch PC <= RESET_PC; pending fe_ack ignored.
REQ-028 Reset outputs SHALL be fe_req=fe_enable, fe_addr=RESET_PC (pc_wen=0), de_valid=0, occupancy=0; FIFO data needs no reset.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries without a pop being signalled.

Configuration
REQ-030 Macro STAGE_PREFETCH_BYPASS_EN: when defined, with count=0, pc_wen=0, fe_req&fe_ack, the block SHALL drive de_valid=1, de_insn=fe_data, de_pc=fe_addr same cycle, and push only if de_ready=0.
REQ-031 When STAGE_PREFETCH_BYPASS_EN is undefined, minimum fetch-to-decode latency SHALL be one cycle (entry visible the cycle after fe_ack).

Verification
REQ-032 Reset, fe_enable=1, fe_ack=1 every cycle, de_ready=0 -> addresses 80000000,04,08,0C pushed; fe_req=0 at occupancy=4.
REQ-033 Full queue, de_ready=1, fe_ack=1 -> one pop/cycle, fe_req resumes next cycle, de_pc sequence 80000000,04,08,... unbroken.
REQ-034 Occupancy=3, pc_wen=1, pc_in=80001000, fe_ack=1, fe_data=00000013 -> de_valid=0 that cycle; next cycle occupancy=1, de_pc=80001000, fe_addr=80001004.
REQ-035 Fetch PC=FFFFFFFC, fe_ack=1 -> entry pc FFFFFFFC, next fe_addr=00000000.
REQ-036 DEPTH=2, empty, fe_ack=1, de_ready=1 -> with BYPASS_EN de_valid=1 same cycle, occupancy stays 0; without, de_valid=1 next cycle.
REQ-037 Occupancy=2, reset_n=0 one cycle -> occupancy=0, de_valid=0, fe_addr=80000000.
